// File: rtl/mux_arbiter_4.sv
// Round-robin arbiter driving the select and enable of a 4:1 multiplexer.
// It bounds how long an owner may hold the grant while others wait, and idles one cycle between owners.
module mux_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Req,
    output logic [3:0] Grant,
    output logic [1:0] Sel,
    output logic       MuxEnable,
    output logic       Preempt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] CNT_MAX  = 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic       preempt_q, preempt_d;
    logic       others_req;

    // First asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + i[1:0];
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        preempt_d  = 1'b0;
        others_req = |(Req & ~one_hot(owner_q));

        case (state_q)
            ST_IDLE: begin
                if (|Req) begin
                    state_d = ST_GRANT;
                    owner_d = rr_pick(Req, ptr_q);
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!Req[owner_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q + 2'd1;
                end else if (cnt_q == CNT_MAX && others_req) begin
                    state_d   = ST_IDLE;
                    ptr_d     = owner_q + 2'd1;
                    preempt_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so a grant appears one edge after the request.
        grant_d = (state_d == ST_GRANT) ? one_hot(owner_d) : 4'b0000;
        sel_d   = (state_d == ST_GRANT) ? owner_d : sel_q;
        en_d    = (state_d == ST_GRANT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            en_q      <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            preempt_q <= preempt_d;
        end
    end

    assign Grant     = grant_q;
    assign Sel       = sel_q;
    assign MuxEnable = en_q;
    assign Preempt   = preempt_q;

endmodule

// File: doc/mux_arbiter_4.md
MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8, legal range 2..255: maximum consecutive cycles one requester may hold the grant while another requester is pending.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 Req  input  4  request lines; bit i is requester i, which drives MuxIn_i of the 4:1 multiplexer.
REQ-005 Grant  output  4  registered one-hot grant; all zero when no requester owns the multiplexer.
REQ-006 Sel  output  2  registered select for the multiplexer; equals the index of the current owner.
REQ-007 MuxEnable  output  1  registered enable for the multiplexer; high only while a grant is active.
REQ-008 Preempt  output  1  registered one-cycle pulse, high in the cycle after a forced release.

Function
REQ-009 The controller SHALL be a two-state FSM with states IDLE and GRANT, plus the following registers: owner[1:0], round-robin pointer Ptr[1:0], and hold counter Cnt[7:0].
REQ-010 IDLE, Req==0: the FSM SHALL remain in IDLE.
REQ-011 IDLE, Req!=0: the FSM SHALL select the first asserted bit scanning Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4), load owner with that index, clear Cnt and enter GRANT.
REQ-012 Grant latency SHALL be exactly one cycle: Req sampled at edge N produces Grant, Sel and MuxEnable valid after edge N.
REQ-013 In GRANT, the outputs SHALL be: Grant = one-hot(owner), Sel = owner, MuxEnable = 1.
REQ-014 In IDLE, the outputs SHALL be: Grant = 0 and MuxEnable = 0; Sel holds its last value.
REQ-015 In GRANT, Cnt SHALL increment each cycle and saturate at MAX_HOLD-1.
REQ-016 Voluntary release: when Req[owner]==0 is sampled in GRANT, the FSM SHALL enter IDLE and set Ptr = owner+1 (mod 4).
REQ-017 Forced release: when Req[owner]==1, Cnt==MAX_HOLD-1 and any other Req bit is 1, the FSM SHALL enter IDLE, set Ptr = owner+1 and pulse Preempt in the following cycle.
REQ-018 A sole requester SHALL keep the grant indefinitely: Cnt saturates with no release while no other Req bit is 1.
REQ-019 Every release SHALL be followed by exactly one IDLE cycle (Grant=0, MuxEnable=0) before the next grant, giving a break-before-make handover.
REQ-020 Requests asserted or dropped by non-owners during GRANT SHALL NOT affect owner, Sel or Grant.
REQ-021 Simultaneous requests in IDLE SHALL be resolved by the pointer order of REQ-011 only; there is no fixed priority.
REQ-022 Grant SHALL never have more than one bit set; MuxEnable SHALL equal |Grant in every cycle.

Reset
REQ-023 With Reset high at an edge, the block SHALL enter IDLE and set: Grant=0, Sel=0, MuxEnable=0, Preempt=0, owner=0, Ptr=0, Cnt=0.
REQ-024 Reset SHALL take priority over all FSM transitions, including mid-GRANT; the cycle after reset deasserts behaves as IDLE with Ptr=0.

Verification
REQ-025 Reset, then Req=0100 for 3 cycles then 0000 -> Grant=0100, Sel=2, MuxEnable=1 from the cycle after Req rises; one IDLE cycle after the drop; Ptr=3.
REQ-026 Reset, then Req=1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0 in turn, each holding 8 cycles, separated by single IDLE cycles, with a Preempt pulse after each handover.
REQ-027 Reset, then Req=0001 held for 300 cycles -> Grant stays 0001 and Preempt never fires.
REQ-028 Owner 1 is granted; assert Req=1011, then drop bit 1 -> next owner is 3 (not 0), after one IDLE cycle.
REQ-029 Reset pulsed during GRANT with owner=2 -> next cycle all outputs 0; with Req=1111, the subsequent grant goes to owner 0.
REQ-030 Assertions on every cycle: Grant one-hot-or-zero; MuxEnable == |Grant; Sel == index(Grant) whenever Grant != 0.
